ex_div_unit: RTL and testbench

Iterative 32-bit integer divider in the EX stage of the dual-issue pipeline, executing div.w, mod.w, div.wu and mod.wu. It asserts stall_ex while a division is in flight, freezing the EX->MEM and MEM->WB registers. It also supplies stall_ex_buf, which the MEM stage uses to suppress repeated branch-correction pulses while the pipeline is stalled. The result is muxed into the EX result path for the downstream pipeline register.

---
 rtl/ex_div_if.sv | 22 ++
 rtl/ex_div_unit.sv | 140 ++++++++++++++
 tb/tb_ex_div_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Handshake and data bundle between the EX stage control and the iterative divider.
interface ex_div_if;
    logic        flush;
    logic        stall_dcache;
    logic        div_en;
    logic [1:0]  div_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] div_result;
    logic        stall_ex;
    logic        stall_ex_buf;

    modport master (
        output flush, stall_dcache, div_en, div_op, src1, src2,
        input  div_result, stall_ex, stall_ex_buf
    );

    modport slave (
        input  flush, stall_dcache, div_en, div_op, src1, src2,
        output div_result, stall_ex, stall_ex_buf
    );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative 32-bit restoring divider for div.w/mod.w/div.wu/mod.wu in the EX stage.
// Holds the pipeline via stall_ex for the 33 cycles a division is in flight.
module ex_div_unit (
    input  logic clk,
    input  logic rstn,
    ex_div_if.slave div_if
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] src1_q, src1_d;
    logic [1:0]  op_q, op_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        zero_q, zero_d;
    logic [31:0] res_q;
    logic        stall_buf_q;

    logic        signed_in;
    logic [31:0] abs1, abs2;
    logic [32:0] trial;
    logic        q_neg, r_neg;
    logic [31:0] res_c;
    logic        stall_ex;

    assign signed_in = ~div_if.div_op[1];
    assign abs1      = (signed_in && div_if.src1[31]) ? -div_if.src1 : div_if.src1;
    assign abs2      = (signed_in && div_if.src2[31]) ? -div_if.src2 : div_if.src2;
    // Dividend shifts out of quo MSB-first while quotient bits shift in at the bottom.
    assign trial     = {rem_q, quo_q[31]} - {1'b0, dvsr_q};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        src1_d  = src1_q;
        op_d    = op_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (div_if.div_en && !div_if.flush) begin
                    quo_d   = abs1;
                    rem_d   = '0;
                    dvsr_d  = abs2;
                    src1_d  = div_if.src1;
                    op_d    = div_if.div_op;
                    s1_d    = div_if.src1[31];
                    s2_d    = div_if.src2[31];
                    zero_d  = (div_if.src2 == 32'd0);
                    count_d = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!div_if.stall_dcache) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (div_if.flush) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        q_neg = ~op_q[1] & (s1_q ^ s2_q);
        r_neg = ~op_q[1] & s1_q;
        res_c = '0;
        if (zero_q) begin
            res_c = op_q[0] ? src1_q : 32'hFFFF_FFFF;
        end else if (op_q[0]) begin
            res_c = r_neg ? -rem_q : rem_q;
        end else begin
            res_c = q_neg ? -quo_q : quo_q;
        end
    end

    assign stall_ex = ~div_if.flush &
                      (((state_q == StIdle) && div_if.div_en) || (state_q == StBusy));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            src1_q      <= '0;
            op_q        <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            zero_q      <= 1'b0;
            res_q       <= '0;
            stall_buf_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            src1_q      <= src1_d;
            op_q        <= op_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            zero_q      <= zero_d;
            stall_buf_q <= stall_ex;
            if (state_q == StDone) begin
                res_q <= res_c;
            end
        end
    end

    assign div_if.div_result   = (state_q == StDone) ? res_c : res_q;
    assign div_if.stall_ex     = stall_ex;
    assign div_if.stall_ex_buf = stall_buf_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit with hand-computed results.
module tb_ex_div_unit;

    logic clk;
    logic rstn;
    int   n_total;
    int   n_bad;
    logic prev_stall;

    ex_div_if dif ();

    ex_div_unit dut (
        .clk    (clk),
        .rstn   (rstn),
        .div_if (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; stall_ex_buf must equal stall_ex of the cycle just ended.
    task automatic next_cycle();
        prev_stall = dif.stall_ex;
        @(posedge clk);
        #2;
        check_eq("stall_ex_buf", {31'd0, dif.stall_ex_buf}, {31'd0, prev_stall});
    endtask

    // Starts in an IDLE cycle, ends in the DONE cycle with div_en still high.
    task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int cnt;
        dif.div_en = 1'b1;
        dif.div_op = op;
        dif.src1   = a;
        dif.src2   = b;
        #1;
        cnt = 0;
        while (dif.stall_ex && cnt < 40) begin
            cnt++;
            if (cnt == 2) begin
                dif.src1 = ~a;  // post-capture operand changes must be ignored
                dif.src2 = a;
            end
            next_cycle();
        end
        check_eq({tag, " stall_len"}, cnt, 33);
        check_eq({tag, " result"}, dif.div_result, exp);
    endtask

    initial begin
        n_total          = 0;
        n_bad            = 0;
        prev_stall       = 1'b0;
        rstn             = 1'b0;
        dif.flush        = 1'b0;
        dif.stall_dcache = 1'b0;
        dif.div_en       = 1'b0;
        dif.div_op       = 2'b00;
        dif.src1         = '0;
        dif.src2         = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check_eq("rst div_result", dif.div_result, 32'd0);
        check_eq("rst stall_ex", {31'd0, dif.stall_ex}, 32'd0);
        check_eq("rst stall_ex_buf", {31'd0, dif.stall_ex_buf}, 32'd0);
        next_cycle();

        run_div("div.w 100/7", 2'b00, 32'd100, 32'd7, 32'd14);
        check_eq("done stall_ex", {31'd0, dif.stall_ex}, 32'd0);
        // Hold DONE for three cycles with div_en still asserted.
        dif.stall_dcache = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            check_eq("dcache hold result", dif.div_result, 32'd14);
            check_eq("dcache hold stall_ex", {31'd0, dif.stall_ex}, 32'd0);
        end
        dif.stall_dcache = 1'b0;
        #1;
        next_cycle();
        run_div("mod.w 100/7", 2'b01, 32'd100, 32'd7, 32'd2);
        next_cycle();
        run_div("div.w -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        next_cycle();
        run_div("mod.w -7/2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        next_cycle();
        run_div("div.wu ffffffff/2", 2'b10, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
        next_cycle();
        run_div("mod.wu fffffff9/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1);
        next_cycle();
        run_div("div.w 5/0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
        next_cycle();
        run_div("mod.w 5/0", 2'b01, 32'd5, 32'd0, 32'd5);
        next_cycle();
        run_div("mod.w -7/0", 2'b01, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        next_cycle();
        run_div("div.w ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        next_cycle();
        run_div("mod.w ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        next_cycle();
        run_div("div.wu 1000/10", 2'b10, 32'd1000, 32'd10, 32'd100);
        next_cycle();
        run_div("mod.wu 1000/7", 2'b11, 32'd1000, 32'd7, 32'd6);
        dif.div_en = 1'b0;
        #1;
        next_cycle();
        check_eq("idle stall_ex", {31'd0, dif.stall_ex}, 32'd0);
        check_eq("idle result held", dif.div_result, 32'd6);

        // Flush at the tenth BUSY cycle.
        dif.div_en = 1'b1;
        dif.div_op = 2'b00;
        dif.src1   = 32'd100;
        dif.src2   = 32'd7;
        #1;
        for (int i = 0; i < 10; i++) next_cycle();
        check_eq("busy stall_ex", {31'd0, dif.stall_ex}, 32'd1);
        dif.flush  = 1'b1;
        dif.div_en = 1'b0;
        #1;
        check_eq("flush stall_ex", {31'd0, dif.stall_ex}, 32'd0);
        next_cycle();
        dif.flush = 1'b0;
        #1;
        check_eq("post flush stall_ex", {31'd0, dif.stall_ex}, 32'd0);
        run_div("div.w 9/3", 2'b00, 32'd9, 32'd3, 32'd3);

        // Reset in the middle of BUSY.
        dif.div_en = 1'b0;
        #1;
        next_cycle();
        dif.div_en = 1'b1;
        dif.src1   = 32'd50;
        dif.src2   = 32'd5;
        #1;
        for (int i = 0; i < 6; i++) next_cycle();
        rstn       = 1'b0;
        dif.div_en = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check_eq("midrst stall_ex", {31'd0, dif.stall_ex}, 32'd0);
        check_eq("midrst stall_ex_buf", {31'd0, dif.stall_ex_buf}, 32'd0);
        check_eq("midrst div_result", dif.div_result, 32'd0);
        next_cycle();
        check_eq("midrst idle stall_ex", {31'd0, dif.stall_ex}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
